// File: rtl/lsu_pkg.sv
// Shared types and helpers for the Avalon load/store host.
package lsu_pkg;

    // RV32 load funct3 encodings; stores reuse the B/H/W codes.
    typedef enum logic [2:0] {
        Lb  = 3'b000,
        Lh  = 3'b001,
        Lw  = 3'b010,
        Lbu = 3'b100,
        Lhu = 3'b101
    } mem_funct3_e;

    localparam mem_funct3_e Sb = Lb;
    localparam mem_funct3_e Sh = Lh;
    localparam mem_funct3_e Sw = Lw;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StResp
    } lsu_state_e;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] be_for(mem_funct3_e funct3, logic [1:0] off);
        logic [3:0] base;
        case (funct3)
            Lb, Lbu: base = 4'b0001;
            Lh, Lhu: base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic f3_legal(logic write, logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~write;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a word-aligned one.
    function automatic logic misaligned(logic [2:0] f3, logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/avalon_mm_rw_if.sv
// Avalon-MM read/write bus between one host and one agent.
interface AvalonMmRw #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   host_to_agent;
    logic [DATA_W-1:0]   agent_to_host;
    logic                waitrequest;
    logic                readdatavalid;

    modport Host (
        output address, byteenable, read, write, host_to_agent,
        input  agent_to_host, waitrequest, readdatavalid
    );

    modport Agent (
        input  address, byteenable, read, write, host_to_agent,
        output agent_to_host, waitrequest, readdatavalid
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store shift/byteenable, load shift/extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  mem_funct3_e funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);
    logic [31:0] lane;

    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign be_o    = be_for(funct3_i, off_i);
    assign lane    = rdata_i >> {off_i, 3'b000};

    // Extend the addressed lane according to the load type.
    always_comb begin
        rdata_o = lane;
        case (funct3_i)
            Lb:      rdata_o = {{24{lane[7]}}, lane[7:0]};
            Lh:      rdata_o = {{16{lane[15]}}, lane[15:0]};
            Lbu:     rdata_o = {24'h0, lane[7:0]};
            Lhu:     rdata_o = {16'h0, lane[15:0]};
            default: rdata_o = lane;
        endcase
    end
endmodule

// File: rtl/avalon_lsu_host.sv
// Avalon-MM host for single byte/half/word loads and stores from the execute stage.
module avalon_lsu_host
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    AvalonMmRw.Host           bus
);
    if (DATA_W != 32) begin : g_bad_data_w
        $fatal(1, "avalon_lsu_host supports DATA_W == 32 only");
    end

    lsu_state_e        state_q, state_d;
    logic              write_q;
    mem_funct3_e       funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              bad_req;
    logic              capture;
    logic [31:0]       wdata_sh;
    logic [3:0]        be;
    logic [31:0]       rdata_ext;

    assign accept  = req_valid && (state_q == StIdle);
    assign bad_req = !f3_legal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);

    lsu_lane_align u_align (
        .funct3_i (funct3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus.agent_to_host),
        .wdata_o  (wdata_sh),
        .be_o     (be),
        .rdata_o  (rdata_ext)
    );

    // Next-state: errors skip the bus; a read completes in CMD if data returns with the grant.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = bad_req ? StResp : StCmd;
                end
            end
            StCmd: begin
                if (!bus.waitrequest) begin
                    if (write_q) begin
                        state_d = StResp;
                    end else if (bus.readdatavalid) begin
                        capture = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bus.readdatavalid) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched request; read data is captured already extended.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= Lb;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= mem_funct3_e'(req_funct3);
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= bad_req;
                rdata_q  <= '0;
            end else if (capture) begin
                rdata_q <= rdata_ext;
            end
        end
    end

    // Outputs decode from state so the bus drops the cycle after reset or completion.
    always_comb begin
        req_ready         = (state_q == StIdle);
        resp_valid        = (state_q == StResp);
        resp_rdata        = resp_valid ? rdata_q : 32'h0;
        resp_error        = resp_valid && err_q;
        bus.read          = (state_q == StCmd) && !write_q;
        bus.write         = (state_q == StCmd) && write_q;
        bus.address       = '0;
        bus.byteenable    = '0;
        bus.host_to_agent = '0;
        if (state_q == StCmd) begin
            bus.address    = {addr_q[ADDR_W-1:2], 2'b00};
            bus.byteenable = be;
            if (write_q) begin
                bus.host_to_agent = wdata_sh;
            end
        end
    end
endmodule

// File: tb/tb_avalon_lsu_host.sv
// Scoreboard bench for avalon_lsu_host with a configurable Avalon agent model.
module tb_avalon_lsu_host;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    AvalonMmRw #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    avalon_lsu_host #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          id;
    } resp_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] hta;
        int          len;
        int          id;
    } bus_exp_t;

    resp_exp_t resp_q[$];
    bus_exp_t  bus_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          agent_wait = 0;
    int          agent_delay = 0;
    logic [31:0] agent_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int id, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (vec %0d): got 0x%08h want 0x%08h", nm, id, act, exp);
        end
    endfunction

    // Agent: waitrequest for agent_wait cycles, then readdatavalid agent_delay cycles later.
    initial begin
        int wcnt = 0;
        int dcnt = -1;
        bus_if.waitrequest   = 1'b0;
        bus_if.readdatavalid = 1'b0;
        bus_if.agent_to_host = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk);
            bus_if.readdatavalid = 1'b0;
            bus_if.agent_to_host = 32'h5A5A_5A5A;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    bus_if.readdatavalid = 1'b1;
                    bus_if.agent_to_host = agent_word;
                    dcnt = -1;
                end
            end
            if (!reset && (bus_if.read === 1'b1 || bus_if.write === 1'b1)) begin
                if (wcnt < agent_wait) begin
                    bus_if.waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    bus_if.waitrequest = 1'b0;
                    wcnt = 0;
                    if (bus_if.read === 1'b1) begin
                        if (agent_delay == 0) begin
                            bus_if.readdatavalid = 1'b1;
                            bus_if.agent_to_host = agent_word;
                        end else begin
                            dcnt = agent_delay;
                        end
                    end
                end
            end else begin
                bus_if.waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Response monitor: every resp_valid pops one expectation.
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid === 1'b1) begin
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 want no response");
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_rdata", e.id, resp_rdata, e.rdata);
                    chk("resp_error", e.id, {31'h0, resp_error}, {31'h0, e.err});
                    chk("resp_cycle", e.id, cyc, e.cyc);
                end
            end
        end
    end

    // Bus monitor: command fields on first cycle, stability while held, length at release.
    initial begin
        bus_exp_t    cur;
        logic        prev_act = 1'b0;
        logic        act;
        int          len = 0;
        logic [37:0] prev_cmd = '0;
        logic [37:0] now_cmd;
        cur = '{wr: 1'b0, addr: '0, be: '0, hta: '0, len: 0, id: -1};
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_act = 1'b0;
            end else begin
                act = (bus_if.read === 1'b1) || (bus_if.write === 1'b1);
                now_cmd = {bus_if.read, bus_if.write, bus_if.byteenable, bus_if.address};
                if (bus_if.read === 1'b1 && bus_if.write === 1'b1) begin
                    total++;
                    bad++;
                    $display("FAIL read_and_write: got both high want at most one");
                end
                if (act && !prev_act) begin
                    len = 1;
                    if (bus_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_bus: got addr=0x%08h want no bus cycle",
                                 bus_if.address);
                    end else begin
                        cur = bus_q.pop_front();
                        chk("bus_write", cur.id, {31'h0, bus_if.write}, {31'h0, cur.wr});
                        chk("bus_address", cur.id, bus_if.address, cur.addr);
                        chk("bus_byteenable", cur.id, {28'h0, bus_if.byteenable}, {28'h0, cur.be});
                        chk("bus_host_to_agent", cur.id, bus_if.host_to_agent, cur.hta);
                    end
                end else if (act && prev_act) begin
                    len++;
                    chk("bus_stable_lo", cur.id, now_cmd[31:0], prev_cmd[31:0]);
                    chk("bus_stable_hi", cur.id, {26'h0, now_cmd[37:32]}, {26'h0, prev_cmd[37:32]});
                end else if (!act && prev_act) begin
                    chk("bus_cmd_len", cur.id, len, cur.len);
                end
                prev_act = act;
                prev_cmd = now_cmd;
            end
        end
    end

    // Issue one request; exp_be == 0 means no bus cycle is expected.
    task automatic issue(input int id, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int wt, input int dly, input logic [31:0] word,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input logic [3:0] exp_be, input logic [31:0] exp_hta);
        resp_exp_t r;
        bus_exp_t  b;
        @(negedge clk);
        agent_wait  = wt;
        agent_delay = dly;
        agent_word  = word;
        req_write   = wr;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        chk("req_ready", id, {31'h0, req_ready}, 32'h1);
        r = '{rdata: exp_rd, err: exp_err, cyc: cyc + lat, id: id};
        resp_q.push_back(r);
        if (exp_be != 4'h0) begin
            b = '{wr: wr, addr: {addr[31:2], 2'b00}, be: exp_be, hta: exp_hta,
                  len: wt + 1, id: id};
            bus_q.push_back(b);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 40 && resp_q.size() != 0; i++) @(negedge clk);
        if (resp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout (vec %0d): got no resp_valid want one", id);
            resp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bus_exp_t b;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 0, {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", 0, {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", 0, resp_rdata, 32'h0);
        chk("rst_resp_error", 0, {31'h0, resp_error}, 32'h0);
        chk("rst_read_write", 0, {30'h0, bus_if.read, bus_if.write}, 32'h0);
        chk("rst_byteenable", 0, {28'h0, bus_if.byteenable}, 32'h0);
        chk("rst_address", 0, bus_if.address, 32'h0);
        chk("rst_host_to_agent", 0, bus_if.host_to_agent, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        //    id wr f3      addr          wdata         wt dly word          rdata         err lat be     hta
        issue(1, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0,        32'h0,        0, 2, 4'hF, 32'hDEAD_BEEF);
        issue(2, 1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0, 0, 32'h0,        32'h0,        0, 2, 4'h8, 32'hA500_0000);
        issue(3, 1, 3'b001, 32'h0000_0012, 32'h1234_BEEF, 1, 0, 32'h0,        32'h0,        0, 3, 4'hC, 32'hBEEF_0000);
        issue(4, 0, 3'b000, 32'h0000_0012, 32'h0,        0, 0, 32'h80FF_7F01, 32'hFFFF_FFFF, 0, 2, 4'h4, 32'h0);
        issue(5, 0, 3'b100, 32'h0000_0012, 32'h0,        0, 0, 32'h80FF_7F01, 32'h0000_00FF, 0, 2, 4'h4, 32'h0);
        issue(6, 0, 3'b001, 32'h0000_0012, 32'h0,        0, 0, 32'h80FF_7F01, 32'hFFFF_80FF, 0, 2, 4'hC, 32'h0);
        issue(7, 0, 3'b101, 32'h0000_0012, 32'h0,        0, 0, 32'h80FF_7F01, 32'h0000_80FF, 0, 2, 4'hC, 32'h0);
        issue(8, 0, 3'b000, 32'h0000_0011, 32'h0,        0, 0, 32'h80FF_7F01, 32'h0000_007F, 0, 2, 4'h2, 32'h0);
        issue(9, 0, 3'b010, 32'h0000_0020, 32'h0,        3, 2, 32'h1357_9BDF, 32'h1357_9BDF, 0, 7, 4'hF, 32'h0);
        issue(10, 0, 3'b010, 32'h0000_0004, 32'h0,       0, 1, 32'h2468_ACE0, 32'h2468_ACE0, 0, 3, 4'hF, 32'h0);
        issue(11, 0, 3'b001, 32'h0000_0011, 32'h0,       0, 0, 32'h0,        32'h0,        1, 1, 4'h0, 32'h0);
        issue(12, 0, 3'b010, 32'h0000_0022, 32'h0,       0, 0, 32'h0,        32'h0,        1, 1, 4'h0, 32'h0);
        issue(13, 1, 3'b100, 32'h0000_0010, 32'h0,       0, 0, 32'h0,        32'h0,        1, 1, 4'h0, 32'h0);

        // Reset while waiting in DATA; the agent's late readdatavalid must be ignored.
        @(negedge clk);
        agent_wait  = 0;
        agent_delay = 3;
        agent_word  = 32'hFEED_F00D;
        req_write   = 1'b0;
        req_funct3  = 3'b010;
        req_addr    = 32'h0000_0030;
        req_valid   = 1'b1;
        b = '{wr: 1'b0, addr: 32'h30, be: 4'hF, hta: 32'h0, len: 1, id: 14};
        bus_q.push_back(b);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_ready", 14, {31'h0, req_ready}, 32'h1);
        chk("post_reset_read", 14, {31'h0, bus_if.read}, 32'h0);

        issue(15, 0, 3'b010, 32'h0000_0008, 32'h0,       0, 1, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 0, 3, 4'hF, 32'h0);

        chk("bus_queue_drained", 99, bus_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
